// File: rtl/lane_serializer.sv
// Single-lane parallel-to-serial transmitter: words are shifted out LSB first with a
// qualifying enable, a done pulse on the last bit, and a fixed idle gap between frames.
module lane_serializer #(
  parameter int WIDTH = 64,
  parameter int GAP   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_en,
  output logic             done,
  output logic             busy,
  output logic [1:0]       o_state
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_valid;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [GW-1:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic             r_ser_out, w_ser_out_nxt;
  logic             r_ser_en, w_ser_en_nxt;
  logic             r_done, w_done_nxt;
  logic             w_accept;
  logic             w_load;

  // Handshake: a word is taken on any rising edge with data_valid && data_ready;
  // data_ready depends only on the holding register being empty, never on data_valid.
  assign w_accept = data_valid && !r_hold_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_ser_out_nxt = 1'b0;
    w_ser_en_nxt  = 1'b0;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;
    case (r_state)
      ST_IDLE: w_load = r_hold_valid;
      ST_SHIFT: begin
        if (r_done) begin
          // The last bit is on the line now; this edge closes the frame.
          w_bit_cnt_nxt = '0;
          if (GAP > 0) begin
            w_state_nxt   = ST_GAP;
            w_gap_cnt_nxt = GW'(1);
          end else if (r_hold_valid) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_ser_out_nxt = r_shift[0];
          w_ser_en_nxt  = 1'b1;
          w_shift_nxt   = r_shift >> 1;
          if (r_bit_cnt == BIT_LAST) begin
            w_done_nxt    = 1'b1;
            w_bit_cnt_nxt = '0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      ST_GAP: begin
        // Gap counter holds the number of idle cycles already shown on the line.
        if (r_gap_cnt == GAP_LAST) begin
          w_gap_cnt_nxt = '0;
          if (r_hold_valid) w_load = 1'b1;
          else              w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_load) begin
      w_state_nxt   = ST_SHIFT;
      w_shift_nxt   = r_hold >> 1;
      w_ser_out_nxt = r_hold[0];
      w_ser_en_nxt  = 1'b1;
      w_bit_cnt_nxt = CW'(1);
      w_gap_cnt_nxt = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_ser_out    <= 1'b0;
      r_ser_en     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_ser_out <= w_ser_out_nxt;
      r_ser_en  <= w_ser_en_nxt;
      r_done    <= w_done_nxt;
      if (w_accept) begin
        r_hold       <= P_DATA;
        r_hold_valid <= 1'b1;
      end else if (w_load) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign data_ready = !r_hold_valid;
  assign ser_out    = r_ser_out;
  assign ser_en     = r_ser_en;
  assign done       = r_done;
  assign busy       = (r_state != ST_IDLE) || r_hold_valid;
  assign o_state    = r_state;

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: a GAP=32 instance and a GAP=0 instance, each with a
// deserializer monitor that rebuilds frames and pops expected words from a queue.
module tb_lane_serializer;
  localparam int W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [W-1:0] p_data;
  logic         data_valid;
  logic         data_ready, ser_out, ser_en, done, busy;
  logic [1:0]   state;
  logic [W-1:0] z_p_data;
  logic         z_data_valid;
  logic         z_data_ready, z_ser_out, z_ser_en, z_done, z_busy;
  logic [1:0]   z_state;

  lane_serializer #(.WIDTH(W), .GAP(32)) dut (
    .CLK(clk), .RST(rst), .P_DATA(p_data), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_en(ser_en),
    .done(done), .busy(busy), .o_state(state)
  );

  lane_serializer #(.WIDTH(W), .GAP(0)) dut_g0 (
    .CLK(clk), .RST(rst), .P_DATA(z_p_data), .data_valid(z_data_valid),
    .data_ready(z_data_ready), .ser_out(z_ser_out), .ser_en(z_ser_en),
    .done(z_done), .busy(z_busy), .o_state(z_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] z_exp_q[$];
  int n_pushed  = 0;
  int n_flushed = 0;
  int frames    = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Deserializer model for the GAP=32 instance.
  int           bit_idx = 0;
  logic [W-1:0] rx_word;
  always @(negedge clk) begin
    if (rst) begin
      bit_idx = 0;
    end else if (ser_en) begin
      rx_word[bit_idx] = ser_out;
      bit_idx++;
      if (done || bit_idx == W) begin
        chk("done_at_last_bit", 64'(done), 64'(bit_idx == W));
        if (bit_idx == W) begin
          if (exp_q.size() == 0) chk("sb_depth", 64'(exp_q.size()), 64'd1);
          else begin
            chk("frame_word", rx_word, exp_q.pop_front());
            frames++;
          end
          bit_idx = 0;
        end
      end
    end else begin
      if (bit_idx != 0) begin
        chk("frame_truncated", 64'(bit_idx), 64'd0);
        bit_idx = 0;
      end
      if (ser_out || done) chk("idle_lines", {62'b0, ser_out, done}, 64'd0);
    end
  end

  // Deserializer model for the GAP=0 instance, also tracking the enable run length.
  int           z_idx = 0, z_run = 0, z_run_max = 0, z_frames = 0;
  logic [W-1:0] z_word;
  always @(negedge clk) begin
    if (rst) begin
      z_idx = 0;
      z_run = 0;
    end else if (z_ser_en) begin
      z_word[z_idx] = z_ser_out;
      z_idx++;
      z_run++;
      if (z_run > z_run_max) z_run_max = z_run;
      if (z_done || z_idx == W) begin
        chk("g0_done_at_last_bit", 64'(z_done), 64'(z_idx == W));
        if (z_idx == W) begin
          if (z_exp_q.size() == 0) chk("g0_sb_depth", 64'(z_exp_q.size()), 64'd1);
          else begin
            chk("g0_frame_word", z_word, z_exp_q.pop_front());
            z_frames++;
          end
          z_idx = 0;
        end
      end
    end else begin
      z_run = 0;
      if (z_ser_out || z_done) chk("g0_idle_lines", {62'b0, z_ser_out, z_done}, 64'd0);
    end
  end

  // Drivers start and end at a falling edge; P_DATA is scrambled while not ready.
  task automatic send(input logic [W-1:0] d);
    int waited;
    waited = 0;
    data_valid = 1'b1;
    while (!data_ready && waited < 400) begin
      p_data = {$urandom, $urandom};
      @(negedge clk);
      waited++;
    end
    p_data = d;
    if (!data_ready) chk("send_ready", 64'(data_ready), 64'd1);
    else begin
      exp_q.push_back(d);
      n_pushed++;
    end
    @(posedge clk);
    @(negedge clk);
    data_valid = 1'b0;
    p_data = {$urandom, $urandom};
  endtask

  task automatic send_z(input logic [W-1:0] d);
    int waited;
    waited = 0;
    z_data_valid = 1'b1;
    while (!z_data_ready && waited < 400) begin
      z_p_data = {$urandom, $urandom};
      @(negedge clk);
      waited++;
    end
    z_p_data = d;
    if (!z_data_ready) chk("g0_send_ready", 64'(z_data_ready), 64'd1);
    else z_exp_q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    z_data_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) chk({tag, "_timeout"}, 64'(done), 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("idle_wait", {62'b0, busy, exp_q.size() != 0}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] t1_word;
    logic         ready_seen;
    int           cyc, g, frames_before;

    rst = 1'b1;
    data_valid = 1'b0;
    p_data = '0;
    z_data_valid = 1'b0;
    z_p_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_ser_out", 64'(ser_out), 64'd0);
    chk("reset_ser_en", 64'(ser_en), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_data_ready", 64'(data_ready), 64'd1);
    chk("reset_state", 64'(state), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_outputs", {59'b0, ser_en, ser_out, done, busy, data_ready}, 64'd1);
    end

    // GAP=0 instance: three words back to back with no bubble.
    send_z({W{1'b1}});
    send_z('0);
    send_z(64'h1);
    g = 0;
    while ((z_busy || z_exp_q.size() != 0) && g < 600) begin
      @(negedge clk);
      g++;
    end
    chk("g0_drained", 64'(z_exp_q.size()), 64'd0);
    chk("g0_frames", 64'(z_frames), 64'd3);
    chk("g0_enable_run", 64'(z_run_max), 64'd192);

    // Single word: latency, LSB-first order, done position, gap start.
    t1_word = 64'h0123_4567_89AB_CDEF;
    send(t1_word);
    chk("t1_ready_after_accept", 64'(data_ready), 64'd0);
    chk("t1_en_before_frame", 64'(ser_en), 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_ser_en", 64'(ser_en), 64'd1);
      chk("t1_bit", 64'(ser_out), 64'(t1_word[k]));
      if (k == 0) chk("t1_ready_after_transfer", 64'(data_ready), 64'd1);
    end
    wait_done("t1_done", cyc);
    chk("t1_done_latency", 64'(cyc), 64'd56);
    @(negedge clk);
    chk("t1_en_fall", 64'(ser_en), 64'd0);
    chk("t1_busy_in_gap", 64'(busy), 64'd1);
    wait_idle(200);

    // Two words, second held during the first frame; gap must be exactly 32.
    send({32{2'b10}});
    repeat (10) @(negedge clk);
    send({32{2'b01}});
    chk("t2_ready_while_held", 64'(data_ready), 64'd0);
    wait_done("t2_done_a", cyc);
    chk("t2_ready_at_done", 64'(data_ready), 64'd0);
    g = 0;
    ready_seen = 1'b0;
    @(negedge clk);
    while (!ser_en && g < 100) begin
      g++;
      if (data_ready) ready_seen = 1'b1;
      @(negedge clk);
    end
    chk("t2_gap_len", 64'(g), 64'd32);
    chk("t2_ready_in_gap", 64'(ready_seen), 64'd0);
    chk("t2_ready_after_transfer", 64'(data_ready), 64'd1);
    wait_done("t2_done_b", cyc);
    wait_idle(200);

    // Backpressure: later words wait with scrambled P_DATA until ready.
    for (int i = 0; i < 4; i++) send({$urandom, $urandom});
    wait_idle(1000);

    // Reset at bit 20 with a second word held: both are abandoned.
    send({$urandom, $urandom});
    send({$urandom, $urandom});
    repeat (19) @(negedge clk);
    chk("t4_mid_frame_en", 64'(ser_en), 64'd1);
    frames_before = frames;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_ser_en", 64'(ser_en), 64'd0);
    chk("t4_rst_done", 64'(done), 64'd0);
    chk("t4_rst_ready", 64'(data_ready), 64'd1);
    chk("t4_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    n_flushed += exp_q.size();
    exp_q.delete();
    repeat (80) @(negedge clk);
    chk("t4_no_frame_after_abort", 64'(frames), 64'(frames_before));
    send(64'h1);
    @(negedge clk);
    chk("t4_new_en", 64'(ser_en), 64'd1);
    chk("t4_new_bit0", 64'(ser_out), 64'd1);
    wait_done("t4_done", cyc);
    @(negedge clk);
    chk("t4_new_frame", 64'(frames), 64'(frames_before + 1));
    wait_idle(200);

    chk("frames_total", 64'(frames), 64'(n_pushed - n_flushed));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Parallel-to-serial transmitter for a single UCIe lane. It accepts a 64-bit word over a valid/ready handshake and shifts it out LSB first, one bit per clock, with a qualifying enable. It then inserts a fixed idle gap before the next word. It drives the far-end deserializer, which captures bit i of the word on the i-th enabled cycle of a frame.

## Interface
Parameters:
- WIDTH, 64, bits per word and frame length in cycles.
- GAP, 32, idle cycles forced between frames. 0 means frames run back-to-back.

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- P_DATA  in  WIDTH  parallel word; sampled only on an accept.
- data_valid  in  1  source has a word on P_DATA.
- data_ready  out  1  holding register empty; equals !hold_valid (combinational).
- ser_out  out  1  serial data, registered, LSB first.
- ser_en  out  1  high exactly on the WIDTH cycles of a frame, registered.
- done  out  1  one-cycle pulse coincident with the last bit (bit WIDTH-1) of a frame.
- busy  out  1  high in SHIFT or GAP, or while hold_valid.

## Operation
- Datapath:
  - hold register (WIDTH) plus hold_valid.
  - shift register (WIDTH).
  - bit counter, $clog2(WIDTH) bits.
  - gap counter, $clog2(GAP+1) bits, minimum 1.
- Accept: data_valid && data_ready at an edge writes P_DATA into hold and sets hold_valid. Otherwise data_valid is ignored, and the source holds P_DATA stable until accepted.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - ser_en=0, ser_out=0.
  - If hold_valid: load shift <= hold >> 1, ser_out <= hold[0], ser_en <= 1, clear hold_valid, bit counter <= 1, go to SHIFT.
- SHIFT:
  - Each cycle: ser_out <= shift[0], shift >>= 1, counter++.
  - When the counter reaches WIDTH-1, that edge drives bit WIDTH-1 and asserts done.
  - Next edge: if GAP>0, go to GAP with ser_en <= 0, ser_out <= 0, gap counter <= 1.
  - If GAP==0 and hold_valid, reload as in IDLE, so ser_en stays high with no bubble.
  - If GAP==0 and !hold_valid, go to IDLE.
- GAP:
  - ser_en=0, ser_out=0; gap counter increments.
  - On the edge where it would reach GAP: reload from hold if hold_valid (ser_en rises, state SHIFT), else go to IDLE.
- Hold is filled independently of FSM state, so the next word can be accepted any time during SHIFT/GAP. Transfer and accept never collide: accept requires hold empty; transfer empties hold.
- RST high at any edge, including mid-frame:
  - State IDLE, hold_valid=0, counters 0.
  - ser_out=0, ser_en=0, done=0; data_ready=1 the following cycle.
  - The partial frame is abandoned, not completed.

## Timing
- Reset values: ser_out 0, ser_en 0, done 0, busy 0, data_ready 1.
- Latency:
  - Accept at edge N (FSM IDLE) gives bit 0 on ser_out with ser_en=1 from edge N+1.
  - Bit k is valid after edge N+1+k.
  - Bit WIDTH-1 and done are valid after edge N+WIDTH; ser_en falls after edge N+WIDTH+1.
- Period with continuous supply is WIDTH+GAP cycles per word. With GAP=0, ser_en remains high across word boundaries.
- data_ready falls the cycle after accept and rises the cycle after the hold→shift transfer.
- done is high for exactly one cycle per completed frame and is never asserted for a frame aborted by RST.

## Test plan
- Single word 0x0123_4567_89AB_CDEF accepted from IDLE → ser_en high 64 cycles starting 1 cycle after accept; ser_out sequence 1,1,1,1,0,1,1,1,…; done on 64th enabled cycle; deserializer model recovers 0x0123_4567_89AB_CDEF.
- Two words 0xAAAA…AAAA then 0x5555…5555, second presented during first frame, GAP=32 → exactly 32 cycles of ser_en=0/ser_out=0 between frames; data_ready low from accept of word 2 until its transfer.
- GAP=0 build, three back-to-back words (0xFFFF…FFFF, 0x0, 0x1) → ser_en continuously high 192 cycles; done pulses at cycles 64, 128, 192.
- Backpressure: hold data_valid high with changing P_DATA while data_ready=0 → only the values present on accept edges are transmitted; no word duplicated or dropped.
- RST asserted at bit 20 of a frame with a second word held → next cycle ser_en=0, done never pulses, data_ready=1, busy=0; a new word 0x1 then transmits normally with bit 0 = 1.
- Idle: no data_valid for 100 cycles after reset → ser_en, ser_out, done, busy stay 0; data_ready stays 1.
